// File: rtl/rgmii_rx_frame.sv
// rgmii_rx_frame: RGMII receive framer that finds preamble/SFD, strips the FCS, checks CRC-32 and length
module rgmii_rx_frame #(
  parameter int MAX_FRAME = 1518,
  parameter int MIN_FRAME = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic [1:0]       rx_ctl,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic             m_good,
  output logic [10:0]      m_len,
  output logic [CNT_W-1:0] cnt_good,
  output logic [CNT_W-1:0] cnt_crc_err,
  output logic [CNT_W-1:0] cnt_len_err,
  output logic [CNT_W-1:0] cnt_phy_err
);
  typedef enum logic [2:0] {SYNC, IDLE, PRE, DATA, DROP} state_t;
  state_t state;
  logic [4:0][7:0] dl;
  logic [31:0] crc;
  logic [10:0] cnt, n;
  logic er, dv, rx_er, len_ok, crc_ok;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  assign dv     = rx_ctl[1];
  assign rx_er  = rx_ctl[1] ^ rx_ctl[0];
  assign n      = cnt + 11'd1;
  assign len_ok = cnt >= 11'(MIN_FRAME);
  assign crc_ok = crc == 32'hDEBB20E3;
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SYNC;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_good      <= 1'b0;
      m_len       <= '0;
      cnt_good    <= '0;
      cnt_crc_err <= '0;
      cnt_len_err <= '0;
      cnt_phy_err <= '0;
      dl          <= '0;
      crc         <= '0;
      cnt         <= '0;
      er          <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_good  <= 1'b0;
      case (state)
        SYNC: if (!dv) state <= IDLE;
        IDLE, PRE: begin
          crc <= 32'hFFFFFFFF;
          cnt <= '0;
          er  <= 1'b0;
          if (!dv) state <= IDLE;
          else if (state == PRE && rx_er) state <= DROP;
          else state <= rx_data == 8'hD5 ? DATA : rx_data == 8'h55 ? PRE : DROP;
        end
        DATA: begin
          if (dv) begin
            crc <= crc_byte(crc, rx_data);
            dl  <= {dl[3:0], rx_data};
            cnt <= n;
            er  <= er | rx_er;
            if (cnt >= 11'd5) begin
              m_valid <= 1'b1;
              m_data  <= dl[4];
            end
            // giant: close the frame now so the byte counter never needs more than 11 bits
            if (n == 11'(MAX_FRAME + 1)) begin
              m_last      <= 1'b1;
              m_len       <= n - 11'd5;
              cnt_len_err <= cnt_len_err + CNT_W'(1);
              state       <= DROP;
            end
          end else begin
            state <= IDLE;
            if (cnt >= 11'd5) begin
              m_valid <= 1'b1;
              m_last  <= 1'b1;
              m_data  <= dl[4];
              m_len   <= cnt - 11'd4;
              m_good  <= crc_ok && len_ok && !er;
              if (!len_ok) cnt_len_err <= cnt_len_err + CNT_W'(1);
              else if (er) cnt_phy_err <= cnt_phy_err + CNT_W'(1);
              else if (!crc_ok) cnt_crc_err <= cnt_crc_err + CNT_W'(1);
              else cnt_good <= cnt_good + CNT_W'(1);
            end else cnt_len_err <= cnt_len_err + CNT_W'(1);
          end
        end
        DROP: if (!dv) state <= IDLE;
        default: state <= SYNC;
      endcase
    end
  end
endmodule
